// File: rtl/cram_pkg.sv
// Shared CRAM definitions: chain-length helpers and the loader state encoding.
package cram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } cram_ld_state_t;

  // Mux select width for one routing-bus input choice (bus lanes plus constants).
  function automatic int unsigned sel_bits(input int unsigned bus_width);
    return $clog2(2 * bus_width + 2);
  endfunction

  // Total serial CRAM chain length of one fpgacell.
  function automatic int unsigned cfg_bits(input int unsigned bus_width,
                                           input int unsigned le_inputs,
                                           input int unsigned le_outputs,
                                           input int unsigned le_lut_size);
    return bus_width * 8
         + 4 * (le_inputs + le_outputs) * sel_bits(bus_width)
         + 4 * (le_lut_size + 1);
  endfunction

endpackage

// File: rtl/cram_word_serializer.sv
// Word-to-bit serializer: one holding word feeding a shift register, MSB first,
// with the leading pad bits of the first word of a load dropped.
module cram_word_serializer #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned PAD    = 0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] word,
  output logic              bit_avail,
  output logic              bit_out,
  output logic              hold_empty
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              first_q, first_d;
  logic              refill;

  assign bit_avail  = (cnt_q != '0);
  assign bit_out    = sreg_q[WORD_W-1];
  assign hold_empty = !full_q;

  // The holding word drops in the same cycle the shift register runs dry.
  always_comb begin
    sreg_d  = sreg_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    first_d = first_q;
    refill  = full_q && ((cnt_q == '0) || (pop && (cnt_q == CNT_W'(1))));
    if (clear) begin
      sreg_d  = '0;
      hold_d  = '0;
      cnt_d   = '0;
      full_d  = 1'b0;
      first_d = 1'b1;
    end else if (en) begin
      if (pop) begin
        sreg_d = sreg_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
      end
      if (refill) begin
        sreg_d  = first_q ? (hold_q << PAD) : hold_q;
        cnt_d   = first_q ? CNT_W'(WORD_W - PAD) : CNT_W'(WORD_W);
        first_d = 1'b0;
        full_d  = 1'b0;
      end else if (push) begin
        hold_d = word;
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sreg_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      sreg_q  <= sreg_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/cram_config_loader.sv
// Loads one fpgacell CRAM chain from a parallel word stream, holding the
// logic elements in reset until the whole chain has been shifted.
module cram_config_loader
  import cram_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned LE_INPUTS   = 4,
  parameter int unsigned LE_OUTPUTS  = 1,
  parameter int unsigned LE_LUT_SIZE = 16,
  parameter int unsigned WORD_W      = 8,
  parameter int unsigned CFG_BITS    = cfg_bits(BUS_WIDTH, LE_INPUTS, LE_OUTPUTS, LE_LUT_SIZE)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              config_data_in,
  output logic              config_en,
  output logic              le_nrst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned NWORDS = (CFG_BITS + WORD_W - 1) / WORD_W;
  localparam int unsigned PAD    = NWORDS * WORD_W - CFG_BITS;
  localparam int unsigned CNT_W  = $clog2(CFG_BITS + 1);
  localparam int unsigned WCNT_W = $clog2(NWORDS + 1);

  cram_ld_state_t    state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic              cfg_en_d, cfg_data_d, done_d, err_d, le_nrst_d, busy_d;
  logic              clear, pop, push;
  logic              bit_avail, bit_out, hold_empty;

  // Words beyond the chain length are refused even if the buffer has room.
  assign word_ready = en && (state_q == LOAD) && hold_empty
                      && (word_cnt_q != WCNT_W'(NWORDS));
  assign push       = word_valid && word_ready;

  cram_word_serializer #(
    .WORD_W (WORD_W),
    .PAD    (PAD)
  ) u_ser (
    .clk        (clk),
    .nrst       (nrst),
    .en         (en),
    .clear      (clear),
    .push       (push),
    .pop        (pop),
    .word       (word_in),
    .bit_avail  (bit_avail),
    .bit_out    (bit_out),
    .hold_empty (hold_empty)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    cfg_en_d   = 1'b0;
    cfg_data_d = config_data_in;
    done_d     = 1'b0;
    err_d      = err;
    le_nrst_d  = le_nrst;
    busy_d     = busy;
    clear      = 1'b0;
    pop        = 1'b0;
    if (push) word_cnt_d = word_cnt_q + WCNT_W'(1);
    if (en) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start && abort) begin
            state_d = IDLE;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else if (start) begin
            state_d    = LOAD;
            clear      = 1'b1;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            err_d      = 1'b0;
            le_nrst_d  = 1'b0;
            busy_d     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          // An aborted chain stays in reset: partial configs are never released.
          if (abort) begin
            state_d = IDLE;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            clear   = 1'b1;
          end else if (bit_cnt_q == CNT_W'(CFG_BITS)) begin
            state_d = FLUSH;
          end else if (bit_avail) begin
            pop        = 1'b1;
            cfg_en_d   = 1'b1;
            cfg_data_d = bit_out;
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end
        end
        FLUSH: begin
          state_d   = DONE;
          done_d    = 1'b1;
          le_nrst_d = 1'b1;
          busy_d    = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      word_cnt_q     <= '0;
      config_en      <= 1'b0;
      config_data_in <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      le_nrst        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      word_cnt_q     <= word_cnt_d;
      config_en      <= cfg_en_d;
      config_data_in <= cfg_data_d;
      done           <= done_d;
      err            <= err_d;
      le_nrst        <= le_nrst_d;
      busy           <= busy_d;
    end
  end

endmodule

// File: tb/tb_cram_config_loader.sv
// Directed bench for cram_config_loader: default 232-bit chain plus a
// 230-bit variant for first-word pad skipping.
`timescale 1ns/1ps
module tb_cram_config_loader;

  localparam int NW = 29;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       en = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] word_in = 8'h00;
  logic       start_a = 1'b0, valid_a = 1'b0;
  logic       start_b = 1'b0, valid_b = 1'b0;
  logic       ready_a, cd_a, ce_a, le_a, busy_a, done_a, err_a;
  logic       ready_b, cd_b, ce_b, le_b, busy_b, done_b, err_b;
  logic       use_b = 1'b0;
  logic       m_ready, m_cd, m_ce, m_le, m_done;

  int checks = 0;
  int failures = 0;

  logic [7:0] words [NW];
  bit         exp_bits[$];
  bit         bits[$];
  int         en_runs, last_bit_t, done_t, done_cnt, extra_acc, freeze_bad, le_bad, abort_t;
  bit         le_at_done, timed_out;

  always #5 clk = ~clk;

  cram_config_loader dut_a (
    .clk(clk), .nrst(nrst), .en(en), .start(start_a), .abort(abort),
    .word_in(word_in), .word_valid(valid_a), .word_ready(ready_a),
    .config_data_in(cd_a), .config_en(ce_a), .le_nrst(le_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  cram_config_loader #(.CFG_BITS(230)) dut_b (
    .clk(clk), .nrst(nrst), .en(en), .start(start_b), .abort(abort),
    .word_in(word_in), .word_valid(valid_b), .word_ready(ready_b),
    .config_data_in(cd_b), .config_en(ce_b), .le_nrst(le_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  assign m_ready = use_b ? ready_b : ready_a;
  assign m_cd    = use_b ? cd_b    : cd_a;
  assign m_ce    = use_b ? ce_b    : ce_a;
  assign m_le    = use_b ? le_b    : le_a;
  assign m_done  = use_b ? done_b  : done_a;

  // Build the word stream and the bit sequence the chain must receive.
  task automatic fill(input bit sel);
    int pad;
    pad = sel ? 2 : 0;
    exp_bits.delete();
    for (int i = 0; i < NW; i++) begin
      words[i] = 8'((i * 53 + 17) ^ 8'h5A);
      if (sel && i == 0) words[i] = 8'hC0;
      for (int b = 7; b >= 0; b--)
        if (!(i == 0 && b > 7 - pad)) exp_bits.push_back(words[i][b]);
    end
  endtask

  function automatic int stream_errs();
    int n;
    n = 0;
    if (bits.size() != exp_bits.size()) return -1;
    foreach (bits[i]) if (bits[i] !== exp_bits[i]) n++;
    return n;
  endfunction

  // One load: start pulse, feed words with 'gap' cycles per word, optional
  // abort / 10-cycle enable drop keyed on the number of bits shifted so far.
  task automatic run_load(input bit sel, input int gap, input int abort_at, input int freeze_at);
    int  idx, wait_c, frz;
    bit  prev_ce, aborted, frz_prev, frz_used, v;
    use_b = sel;
    bits.delete();
    en_runs = 0; last_bit_t = -1; done_t = -1; done_cnt = 0; extra_acc = 0;
    freeze_bad = 0; le_bad = 0; le_at_done = 0; timed_out = 1; abort_t = -1;
    idx = 0; wait_c = 0; frz = 0; prev_ce = 0; aborted = 0; frz_prev = 0; frz_used = 0;
    en = 1'b1;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      if (m_ce) begin
        bits.push_back(m_cd);
        last_bit_t = t;
        if (!prev_ce) en_runs++;
        if (m_le) le_bad++;
      end
      if (frz_prev && m_ce) freeze_bad++;
      if (m_done) begin done_t = t; done_cnt++; le_at_done = m_le; end
      prev_ce = m_ce;
      if ((done_t >= 0 && t >= done_t + 2) || (aborted && t >= abort_t + 3)) begin
        timed_out = 0;
        break;
      end
      abort = 1'b0;
      if (abort_at >= 0 && !aborted && bits.size() == abort_at) begin
        abort = 1'b1; aborted = 1; abort_t = t;
      end
      if (freeze_at >= 0 && !frz_used && bits.size() == freeze_at) begin
        frz = 10; frz_used = 1;
      end
      en = (frz == 0);
      frz_prev = (frz != 0);
      if (frz > 0) frz--;
      if (idx < NW) begin
        if (wait_c == 0) begin v = 1; word_in = words[idx]; end
        else begin v = 0; wait_c--; end
      end else begin
        v = 1; word_in = 8'hFF;
      end
      valid_a = sel ? 1'b0 : v;
      valid_b = sel ? v : 1'b0;
      #1;
      if (v && m_ready) begin
        if (idx < NW) begin idx++; wait_c = gap - 1; end
        else extra_acc++;
      end
      @(negedge clk);
    end
    valid_a = 1'b0; valid_b = 1'b0; abort = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset;
    #2 nrst = 1'b0;
    @(negedge clk);
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL reset_word_ready: got %b want 0", ready_a); end
    checks++; if (ce_a !== 1'b0) begin failures++; $display("FAIL reset_config_en: got %b want 0", ce_a); end
    checks++; if (cd_a !== 1'b0) begin failures++; $display("FAIL reset_config_data_in: got %b want 0", cd_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_a); end
    checks++; if (le_a !== 1'b0) begin failures++; $display("FAIL reset_le_nrst: got %b want 0", le_a); end
    @(negedge clk);
    nrst = 1'b1;
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_load;
    fill(0);
    run_load(0, 1, -1, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL full_timeout: got no done want done"); end
    checks++; if (bits.size() != 232) begin failures++; $display("FAIL full_bit_count: got %0d want 232", bits.size()); end
    checks++; if (en_runs != 1) begin failures++; $display("FAIL full_contiguous: got %0d runs want 1", en_runs); end
    checks++; if (stream_errs() != 0) begin failures++; $display("FAIL full_stream: got %0d bad bits want 0", stream_errs()); end
    checks++; if (done_t - last_bit_t != 2) begin failures++; $display("FAIL full_done_latency: got %0d want 2", done_t - last_bit_t); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL full_done_pulse: got %0d want 1", done_cnt); end
    checks++; if (le_at_done !== 1'b1) begin failures++; $display("FAIL full_le_at_done: got %b want 1", le_at_done); end
    checks++; if (le_bad != 0) begin failures++; $display("FAIL full_le_during_load: got %0d want 0", le_bad); end
    checks++; if (extra_acc != 0) begin failures++; $display("FAIL full_surplus_word: got %0d want 0", extra_acc); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL full_busy_after: got %b want 0", busy_a); end
  endtask

  task automatic test_sparse_words;
    fill(0);
    run_load(0, 12, -1, -1);
    checks++; if (bits.size() != 232) begin failures++; $display("FAIL sparse_bit_count: got %0d want 232", bits.size()); end
    checks++; if (stream_errs() != 0) begin failures++; $display("FAIL sparse_stream: got %0d bad bits want 0", stream_errs()); end
    checks++; if (en_runs != 29) begin failures++; $display("FAIL sparse_gaps: got %0d runs want 29", en_runs); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL sparse_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_freeze;
    fill(0);
    run_load(0, 1, -1, 50);
    checks++; if (freeze_bad != 0) begin failures++; $display("FAIL freeze_config_en: got %0d want 0", freeze_bad); end
    checks++; if (en_runs != 2) begin failures++; $display("FAIL freeze_runs: got %0d want 2", en_runs); end
    checks++; if (bits.size() != 232) begin failures++; $display("FAIL freeze_bit_count: got %0d want 232", bits.size()); end
    checks++; if (stream_errs() != 0) begin failures++; $display("FAIL freeze_stream: got %0d bad bits want 0", stream_errs()); end
  endtask

  task automatic test_abort;
    fill(0);
    run_load(0, 1, 100, -1);
    checks++; if (bits.size() != 100) begin failures++; $display("FAIL abort_bit_count: got %0d want 100", bits.size()); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy_a); end
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL abort_err: got %b want 1", err_a); end
    checks++; if (le_a !== 1'b0) begin failures++; $display("FAIL abort_le_nrst: got %b want 0", le_a); end
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL abort_word_ready: got %b want 0", ready_a); end
    run_load(0, 1, -1, -1);
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reload_err_cleared: got %b want 0", err_a); end
    checks++; if (stream_errs() != 0) begin failures++; $display("FAIL reload_stream: got %0d bad bits want 0", stream_errs()); end
    checks++; if (le_a !== 1'b1) begin failures++; $display("FAIL reload_le_nrst: got %b want 1", le_a); end
  endtask

  task automatic test_start_abort_same;
    @(negedge clk);
    start_a = 1'b1; abort = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort = 1'b0;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL start_abort_busy: got %b want 0", busy_a); end
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL start_abort_err: got %b want 1", err_a); end
    @(negedge clk);
    checks++; if (ce_a !== 1'b0) begin failures++; $display("FAIL start_abort_config_en: got %b want 0", ce_a); end
  endtask

  task automatic test_pad_skip;
    fill(1);
    run_load(1, 1, -1, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL pad_timeout: got no done want done"); end
    checks++; if (bits.size() != 230) begin failures++; $display("FAIL pad_bit_count: got %0d want 230", bits.size()); end
    checks++; if (stream_errs() != 0) begin failures++; $display("FAIL pad_stream: got %0d bad bits want 0", stream_errs()); end
    checks++; if (le_b !== 1'b1) begin failures++; $display("FAIL pad_le_nrst: got %b want 1", le_b); end
    use_b = 1'b0;
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL midreset_busy_before: got %b want 1", busy_a); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b want 0", busy_a); end
    checks++; if (le_a !== 1'b0) begin failures++; $display("FAIL midreset_le_nrst: got %b want 0", le_a); end
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL midreset_word_ready: got %b want 0", ready_a); end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_sparse_words();
    test_freeze();
    test_abort();
    test_start_abort_same();
    test_pad_skip();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
